// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared definitions for the data-memory responder: data width,
//               word-alignment mask, error codes, FSM state encoding and the
//               request address check.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int          c_DATA_W          = 32;
    localparam logic [31:0] c_WORD_ALIGN_MASK = 32'h0000_0003;

    localparam logic c_ERR_NONE   = 1'b0;
    localparam logic c_ERR_ACCESS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A request is in error when it is not word aligned or when its word
    // index does not fit in wordIdxBits bits (i.e. index >= DEPTH).
    function automatic logic addrError(input logic [31:0] addr, input int wordIdxBits);
        logic [31:0] w_hi;
        w_hi = addr >> (wordIdxBits + 2);
        return ((addr & c_WORD_ALIGN_MASK) != 32'd0) || (w_hi != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : CPU data-memory request/response bundle.
//               master : pipeline memory stage (initiator)
//               slave  : dmem_responder (target)
//   req_valid/req_we/req_addr/req_wdata : request, held until req_ready
//   req_ready                           : target can accept
//   resp_valid/resp_rdata/resp_err      : response, held until resp_ready
//   resp_ready                          : initiator consumes response
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic                req_valid;
    logic                req_we;
    logic [31:0]         req_addr;
    logic [c_DATA_W-1:0] req_wdata;
    logic                req_ready;
    logic                resp_valid;
    logic                resp_ready;
    logic [c_DATA_W-1:0] resp_rdata;
    logic                resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_array
// Description : Single-port synchronous RAM, DEPTH x DATA_W, with write enable
//               and registered read data. Contents are not reset.
//   clk     in  clock
//   i_en    in  access enable (read or write this cycle)
//   i_we    in  1 = write i_wdata, 0 = read into o_rdata
//   i_addr  in  word index
//   i_wdata in  write data
//   o_rdata out read data, updated one cycle after an enabled read
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Target side of the CPU data-memory interface. Accepts one
//               load/store at a time, models access latency and returns read
//               data or an error for misaligned / out-of-range addresses.
//   clk  in    rising-edge clock
//   rst  in    synchronous active-high reset (array contents are kept)
//   bus  slave dmem_responder_if request/response handshake
// Parameters  : DEPTH (words, power of two), WAIT_CYCLES (0..15)
// Build macro : DMEM_WAIT_STATES_EN - when defined a WAIT state with a
//               down-counter gives latency WAIT_CYCLES+1; when undefined the
//               latency is fixed at 1 cycle and WAIT_CYCLES is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int c_AW = $clog2(DEPTH);

`ifdef DMEM_WAIT_STATES_EN
    localparam bit c_DIRECT_RESP = (WAIT_CYCLES == 0);
`else
    localparam bit c_DIRECT_RESP = 1'b1;
`endif

    if (DEPTH != (1 << c_AW)) begin : g_depthCheck
        $error("dmem_responder: DEPTH must be a power of two");
    end

    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_waitCheck
        $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end

    state_t              r_state;
    logic                r_reqReady;
    logic                r_respValid;
    logic                r_reqWe;
    logic                r_reqErr;
    logic [c_AW-1:0]     r_reqIdx;
    logic [c_DATA_W-1:0] r_reqWdata;
`ifdef DMEM_WAIT_STATES_EN
    logic [3:0]          r_waitCnt;
`endif

    logic                w_accept;
    logic                w_inErr;
    logic                w_enterResp;
    logic                w_memEn;
    logic                w_memWe;
    logic                w_memErr;
    logic [c_AW-1:0]     w_memIdx;
    logic [c_DATA_W-1:0] w_memWdata;
    logic [c_DATA_W-1:0] w_arrRdata;

    assign w_accept = bus.req_valid && r_reqReady;
    assign w_inErr  = addrError(bus.req_addr, c_AW);

    // The array is touched exactly on the edge that moves the FSM into RESP.
    // Coming straight from IDLE the live request is used; coming from WAIT
    // the captured copy is used.
    always_comb begin
        w_enterResp = 1'b0;
        w_memWe     = bus.req_we;
        w_memErr    = w_inErr;
        w_memIdx    = bus.req_addr[c_AW+1:2];
        w_memWdata  = bus.req_wdata;
        if (r_state == ST_IDLE) begin
            w_enterResp = w_accept && c_DIRECT_RESP;
        end else begin
            w_memWe    = r_reqWe;
            w_memErr   = r_reqErr;
            w_memIdx   = r_reqIdx;
            w_memWdata = r_reqWdata;
`ifdef DMEM_WAIT_STATES_EN
            w_enterResp = (r_state == ST_WAIT) && (r_waitCnt == 4'd1);
`endif
        end
    end

    // rst on the committing edge must suppress the write of a dropped store.
    assign w_memEn = w_enterResp && !rst && !w_memErr;

    dmem_responder_array #(
        .DEPTH  (DEPTH),
        .DATA_W (c_DATA_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_memEn),
        .i_we    (w_memWe),
        .i_addr  (w_memIdx),
        .i_wdata (w_memWdata),
        .o_rdata (w_arrRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_reqWe     <= 1'b0;
            r_reqErr    <= c_ERR_NONE;
            r_reqIdx    <= '0;
            r_reqWdata  <= '0;
`ifdef DMEM_WAIT_STATES_EN
            r_waitCnt   <= 4'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_reqWe    <= bus.req_we;
                        r_reqErr   <= w_inErr;
                        r_reqIdx   <= bus.req_addr[c_AW+1:2];
                        r_reqWdata <= bus.req_wdata;
                        r_reqReady <= 1'b0;
                        if (c_DIRECT_RESP) begin
                            r_state     <= ST_RESP;
                            r_respValid <= 1'b1;
                        end
`ifdef DMEM_WAIT_STATES_EN
                        else begin
                            r_state   <= ST_WAIT;
                            r_waitCnt <= 4'(WAIT_CYCLES);
                        end
`endif
                    end
                end
`ifdef DMEM_WAIT_STATES_EN
                ST_WAIT: begin
                    r_waitCnt <= r_waitCnt - 4'd1;
                    if (r_waitCnt == 4'd1) begin
                        r_state     <= ST_RESP;
                        r_respValid <= 1'b1;
                    end
                end
`endif
                ST_RESP: begin
                    // req_ready rises only on the following cycle, so a new
                    // request can never be taken in the consuming cycle.
                    if (bus.resp_ready) begin
                        r_state     <= ST_IDLE;
                        r_respValid <= 1'b0;
                        r_reqReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_respValid <= 1'b0;
                    r_reqReady  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_reqReady;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_err   = r_respValid ? r_reqErr : c_ERR_NONE;
    // Array read register holds still during RESP; gate it to zero for
    // stores, errors and whenever no response is being presented.
    assign bus.resp_rdata = (r_respValid && !r_reqWe && !r_reqErr) ? w_arrRdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A monitor compares
//               every response against a word-array model of the memory;
//               directed cases pin literal values, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH       = 1024;
    localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_STATES_EN
    localparam int c_LAT = WAIT_CYCLES + 1;
`else
    localparam int c_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int issued    = 0;
    int respCount = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          acc;
        bit          seen;
        logic        expErr;
        logic [31:0] expData;
        bit          dataKnown;
    } txn_t;

    txn_t        q[$];
    logic [31:0] mdl [int];
    logic        rstPrev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one pending transaction at most; its expectation is taken from
    // the word model when the response first appears (that is when a store
    // commits), and re-checked every cycle the response is held.
    always @(negedge clk) begin : monitor
        txn_t        t;
        logic [31:0] idx;
        if (rstPrev && !rst) begin
            chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
            chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
            chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
            chk("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
        end
        if (rst) begin
            q.delete();
        end else begin
            chk("req_ready_vs_idle", {31'd0, bus.req_ready}, {31'd0, (q.size() == 0)});
            if (q.size() == 0) begin
                chk("resp_valid_idle", {31'd0, bus.resp_valid}, 32'd0);
            end else if (bus.resp_valid) begin
                t = q[0];
                if (!t.seen) begin
                    t.seen      = 1'b1;
                    idx         = t.addr >> 2;
                    t.expErr    = (t.addr[1:0] != 2'b00) || (t.addr >= 32'(DEPTH * 4));
                    t.dataKnown = 1'b1;
                    t.expData   = 32'd0;
                    if (!t.expErr && t.we) begin
                        mdl[int'(idx)] = t.wdata;
                    end else if (!t.expErr && !t.we) begin
                        if (mdl.exists(int'(idx))) t.expData = mdl[int'(idx)];
                        else t.dataKnown = 1'b0;
                    end
                    chk("resp_latency", 32'(cyc - t.acc), 32'(c_LAT));
                    q[0] = t;
                end
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, t.expErr});
                if (t.dataKnown) chk("resp_rdata", bus.resp_rdata, t.expData);
                if (bus.resp_ready) begin
                    void'(q.pop_front());
                    respCount++;
                end
            end else if (cyc > q[0].acc + c_LAT) begin
                chk("resp_valid_late", {31'd0, bus.resp_valid}, 32'd1);
            end
            if (bus.req_valid && bus.req_ready) begin
                t = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata,
                      acc: cyc, seen: 1'b0, expErr: 1'b0, expData: 32'd0, dataKnown: 1'b0};
                q.push_back(t);
            end
        end
        rstPrev = rst;
    end

    // Called at posedge+1. Drives one request, waits for the response, holds
    // resp_ready low for 'hold' cycles while pushing junk requests, then
    // consumes the response.
    task automatic doTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = 32'd0; er = 1'b0; lat = -1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) begin
            chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        issued++;
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) begin
            chk("resp_timeout", {31'd0, bus.resp_valid}, 32'd1);
            return;
        end
        lat = n; rd = bus.resp_rdata; er = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10; bus.req_wdata = $urandom;
            @(posedge clk); #1;
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    function automatic logic [31:0] pickAddr(input logic [31:0] base);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return base | 32'($urandom_range(1, 3));
        if (r == 1) return 32'(DEPTH * 4) + (32'($urandom_range(0, 255)) << 2);
        return base;
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] pool [8];

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("post_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);

        doTxn(1'b1, 32'h20, 32'hCAFEF00D, 0, rd, er, lat);
        doTxn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        chk("st10_err", {31'd0, er}, 32'd0);
        chk("st10_rdata", rd, 32'd0);
        doTxn(1'b0, 32'h10, 32'd0, 0, rd, er, lat);
        chk("ld10_rdata", rd, 32'hDEADBEEF);
        chk("ld10_err", {31'd0, er}, 32'd0);
        chk("ld10_latency", 32'(lat), 32'(c_LAT));
        chk("model_word4", mdl[4], 32'hDEADBEEF);

        doTxn(1'b0, 32'h13, 32'd0, 0, rd, er, lat);
        chk("ld13_err", {31'd0, er}, 32'd1);
        chk("ld13_rdata", rd, 32'd0);
        doTxn(1'b0, 32'(DEPTH * 4), 32'd0, 0, rd, er, lat);
        chk("ldoob_err", {31'd0, er}, 32'd1);
        chk("ldoob_rdata", rd, 32'd0);
        doTxn(1'b1, 32'h11, 32'h0BADF00D, 0, rd, er, lat);
        chk("st11_err", {31'd0, er}, 32'd1);

        doTxn(1'b0, 32'h10, 32'd0, 5, rd, er, lat);
        chk("hold_ld10_rdata", rd, 32'hDEADBEEF);

        // Store that is reset before it commits.
        bus.req_valid = 1'b1; bus.req_we = 1'b1;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
`ifdef DMEM_WAIT_STATES_EN
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
`else
        rst = 1'b1;
`endif
        @(posedge clk); #1;
        rst = 1'b0; bus.req_valid = 1'b0;
        chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("midrst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        doTxn(1'b0, 32'h20, 32'd0, 0, rd, er, lat);
        chk("ld20_after_rst", rd, 32'hCAFEF00D);

        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'($urandom_range(0, DEPTH - 1)) << 2;
            doTxn(1'b1, pool[i], $urandom, 0, rd, er, lat);
        end
        for (int i = 0; i < 16; i++) begin
            doTxn(1'b1, pickAddr(pool[$urandom_range(0, 7)]), $urandom,
                  $urandom_range(0, 2), rd, er, lat);
            doTxn(1'b0, pickAddr(pool[$urandom_range(0, 7)]), 32'd0,
                  $urandom_range(0, 2), rd, er, lat);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("resp_count", 32'(respCount), 32'(issued));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
